clk_rst_seq_gen: RTL

Synthesizable, parametrised successor to the bench clock/reset control interface.
- Generates NUM_CH independently programmable divided clocks from one input clock.
- Generates NUM_CH active-low reset outputs, released in channel order with programmable spacing.
- Re-runs the reset sequence on a software request.
- Sits at the top of the subsystem, feeding the UART/APB domains and their benches.

---
 rtl/clk_rst_pkg.sv | 10 +
 rtl/clk_rst_seq_gen_if.sv | 24 ++
 rtl/clk_div_ch.sv | 53 +++++
 rtl/clk_rst_seq_gen.sv | 120 ++++++++++++
 4 files changed

// File: rtl/clk_rst_pkg.sv
// Shared types for the clock/reset sequencing subsystem.
package clk_rst_pkg;

  typedef enum logic [1:0] {
    HOLD,
    RELEASE,
    DONE
  } seq_state_e;

endpackage

// File: rtl/clk_rst_seq_gen_if.sv
// Control/status bundle of clk_rst_seq_gen: divider programming, software
// reset request, divided clocks, ticks and sequenced resets.
interface clk_rst_seq_gen_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DIV_W  = 8
);
  logic [NUM_CH-1:0]       ch_en_i;
  logic [NUM_CH*DIV_W-1:0] div_i;
  logic                    sw_rst_i;
  logic [NUM_CH-1:0]       clk_o;
  logic [NUM_CH-1:0]       tick_o;
  logic [NUM_CH-1:0]       rst_no;
  logic                    seq_done_o;

  modport master (
    output ch_en_i, div_i, sw_rst_i,
    input  clk_o, tick_o, rst_no, seq_done_o
  );

  modport slave (
    input  ch_en_i, div_i, sw_rst_i,
    output clk_o, tick_o, rst_no, seq_done_o
  );
endinterface

// File: rtl/clk_div_ch.sv
// One glitch-free programmable clock divider channel; half period is div_q+1
// cycles, divider value and enable only take effect at a rising boundary.
module clk_div_ch #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             arst_ni,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             clk_o,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;
  logic             running;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      cnt     <= '0;
      div_q   <= '0;
      running <= 1'b0;
      clk_o   <= 1'b0;
      tick_o  <= 1'b0;
    end else begin
      tick_o <= 1'b0;
      if (!running) begin
        if (en_i) begin
          running <= 1'b1;
          clk_o   <= 1'b1;
          cnt     <= '0;
          div_q   <= div_i;
          tick_o  <= 1'b1;
        end
      end else if (cnt != div_q) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
        if (clk_o) begin
          clk_o <= 1'b0;
        end else if (en_i) begin
          clk_o  <= 1'b1;
          tick_o <= 1'b1;
          div_q  <= div_i;
        end else begin
          // A dropped enable is only honoured once the low phase has completed.
          running <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/clk_rst_seq_gen.sv
// NUM_CH divided clocks plus active-low resets released in channel order,
// with a software-triggered restart of the release sequence.
module clk_rst_seq_gen
  import clk_rst_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned DIV_W    = 8,
  parameter int unsigned HOLD_CYC = 16,
  parameter int unsigned GAP_CYC  = 4
) (
  input  logic              clk_i,
  input  logic              arst_ni,
  clk_rst_seq_gen_if.slave  bus
);

  localparam int unsigned HOLD_W = $clog2(HOLD_CYC + 1);
  localparam int unsigned GAP_W  = $clog2(GAP_CYC + 1);
  localparam int unsigned IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] clk_vec;
  logic [NUM_CH-1:0] tick_vec;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    clk_div_ch #(
      .DIV_W (DIV_W)
    ) u_div (
      .clk_i   (clk_i),
      .arst_ni (arst_ni),
      .en_i    (bus.ch_en_i[c]),
      .div_i   (bus.div_i[c*DIV_W +: DIV_W]),
      .clk_o   (clk_vec[c]),
      .tick_o  (tick_vec[c])
    );
  end

  seq_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [IDX_W-1:0]  idx_q, idx_d, idx_inc;
  logic [NUM_CH-1:0] rst_q, rst_d;
  logic              done_q, done_d;

  assign idx_inc = idx_q + 1'b1;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= HOLD;
      hold_q  <= '0;
      gap_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    done_d  = done_q;
    if (bus.sw_rst_i) begin
      state_d = HOLD;
      hold_d  = '0;
      gap_d   = '0;
      idx_d   = '0;
      rst_d   = '0;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        HOLD: begin
          rst_d = '0;
          if (hold_q == HOLD_W'(HOLD_CYC - 1)) begin
            hold_d   = '0;
            gap_d    = '0;
            idx_d    = '0;
            rst_d[0] = 1'b1;
            if (NUM_CH == 1) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = RELEASE;
            end
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        RELEASE: begin
          if (gap_q == GAP_W'(GAP_CYC - 1)) begin
            gap_d          = '0;
            idx_d          = idx_inc;
            rst_d[idx_inc] = 1'b1;
            if (idx_inc == IDX_W'(NUM_CH - 1)) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        DONE: ;
        default: state_d = HOLD;
      endcase
    end
  end

  assign bus.clk_o      = clk_vec;
  assign bus.tick_o     = tick_vec;
  assign bus.rst_no     = rst_q;
  assign bus.seq_done_o = done_q;

endmodule
